// File: rtl/rggen_rtl_pkg.sv
// ---------------------------------------------------------------------------
// rggen_rtl_pkg
// Shared register-bus types for the rggen RTL blocks:
//   rggen_access            - access kind carried on the register bus
//   rggen_status            - response status returned by a register target
//   rggen_bus_arbiter_state - two-state FSM of rggen_bus_arbiter
// It also holds a small helper that wraps a requester index modulo a count.
// ---------------------------------------------------------------------------
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RGGEN_POSTED_WRITE = 2'b01,
      RGGEN_READ         = 2'b10,
      RGGEN_WRITE        = 2'b11
   } rggen_access;

   typedef enum logic [1:0] {
      RGGEN_OKAY         = 2'b00,
      RGGEN_EXOKAY       = 2'b01,
      RGGEN_SLAVE_ERROR  = 2'b10,
      RGGEN_DECODE_ERROR = 2'b11
   } rggen_status;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } rggen_bus_arbiter_state;

   // Upper bound on the number of requesters any arbiter instance may have.
   localparam int RGGEN_MAX_REQUESTERS = 16;

   // Returns (index + 1) mod count for an index held in a 32-bit integer.
   function automatic int unsigned rggen_next_index(
      input int unsigned index,
      input int unsigned count
   );
      int unsigned next_index;
      if (index >= (count - 32'd1)) begin
         next_index = 32'd0;
      end else begin
         next_index = index + 32'd1;
      end
      return next_index;
   endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// rggen_round_robin_arbiter
// Purely combinational round-robin grant selection. The search starts at
// i_pointer and moves upward with wrap-around; the first asserted request
// wins and is reported as a one-hot grant. No request -> all-zero grant.
// Ports:
//   i_request [REQUESTERS]          request vector
//   i_pointer [$clog2(REQUESTERS)]  search start position (< REQUESTERS)
//   o_grant   [REQUESTERS]          one-hot grant
// ---------------------------------------------------------------------------
module rggen_round_robin_arbiter
   import rggen_rtl_pkg::*;
#(
   parameter int REQUESTERS = 2
)(
   input  logic [REQUESTERS-1:0]         i_request,
   input  logic [$clog2(REQUESTERS)-1:0] i_pointer,
   output logic [REQUESTERS-1:0]         o_grant
);

   localparam int PW    = $clog2(REQUESTERS);
   localparam int SUM_W = PW + 1;
   localparam logic [SUM_W-1:0] N_SUM = SUM_W'(REQUESTERS);

   logic [SUM_W-1:0] sum_s;
   logic [PW-1:0]    index_s;
   logic             found_s;

   // Walk the request vector from the pointer upward and keep the first hit.
   always_comb begin
      o_grant = '0;
      sum_s   = '0;
      index_s = '0;
      found_s = 1'b0;
      for (int i = 0; i < REQUESTERS; i++) begin
         // pointer + i never exceeds 2*REQUESTERS-2, so one subtraction wraps it
         sum_s = {1'b0, i_pointer} + SUM_W'(i);
         if (sum_s >= N_SUM) begin
            index_s = PW'(sum_s - N_SUM);
         end else begin
            index_s = PW'(sum_s);
         end
         if (!found_s && i_request[index_s]) begin
            o_grant[index_s] = 1'b1;
            found_s          = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rggen_bus_arbiter
// Shares one rggen register bus among REQUESTERS host ports using
// round-robin arbitration. A grant registers the winner's request fields,
// o_valid rises the following cycle and the fields stay frozen until the
// target returns i_ready. On completion the response is steered
// combinationally to the winner, the pointer moves past it and, if another
// port is waiting, the next access is granted in the same cycle so o_valid
// stays high across back-to-back accesses.
//
// Optional build macro RGGEN_BUS_ARBITER_TIMEOUT_EN: counts BUSY cycles and
// forces completion with RGGEN_SLAVE_ERROR after TIMEOUT_CYCLES cycles
// without i_ready. Without the macro BUSY waits for i_ready indefinitely.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_valid/i_access/i_address/i_write_data/i_strobe
//                           per-requester request, packed port 0 at LSBs
//   o_ready/o_status/o_read_data
//                           per-requester response, packed port 0 at LSBs
//   o_valid/o_access/o_address/o_write_data/o_strobe
//                           shared register bus request (registered)
//   i_ready/i_status/i_read_data
//                           shared register bus response
// ---------------------------------------------------------------------------
module rggen_bus_arbiter
   import rggen_rtl_pkg::*;
#(
   parameter int REQUESTERS     = 2,
   parameter int ADDRESS_WIDTH  = 8,
   parameter int BUS_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 64
)(
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic [REQUESTERS-1:0]                i_valid,
   input  logic [2*REQUESTERS-1:0]              i_access,
   input  logic [ADDRESS_WIDTH*REQUESTERS-1:0]  i_address,
   input  logic [BUS_WIDTH*REQUESTERS-1:0]      i_write_data,
   input  logic [(BUS_WIDTH/8)*REQUESTERS-1:0]  i_strobe,
   output logic [REQUESTERS-1:0]                o_ready,
   output logic [2*REQUESTERS-1:0]              o_status,
   output logic [BUS_WIDTH*REQUESTERS-1:0]      o_read_data,
   output logic                                 o_valid,
   output logic [1:0]                           o_access,
   output logic [ADDRESS_WIDTH-1:0]             o_address,
   output logic [BUS_WIDTH-1:0]                 o_write_data,
   output logic [BUS_WIDTH/8-1:0]               o_strobe,
   input  logic                                 i_ready,
   input  logic [1:0]                           i_status,
   input  logic [BUS_WIDTH-1:0]                 i_read_data
);

   localparam int PW = $clog2(REQUESTERS);
   localparam int SW = BUS_WIDTH / 8;

   rggen_bus_arbiter_state state_q, state_d;
   logic [PW-1:0]            pointer_q, pointer_d;
   logic [PW-1:0]            grant_q, grant_d;
   logic                     valid_q, valid_d;
   logic [1:0]               access_q, access_d;
   logic [ADDRESS_WIDTH-1:0] address_q, address_d;
   logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
   logic [SW-1:0]            strobe_q, strobe_d;

   logic [REQUESTERS-1:0]    arb_request_s;
   logic [REQUESTERS-1:0]    arb_grant_s;
   logic [PW-1:0]            arb_pointer_s;
   logic [PW-1:0]            arb_index_s;
   logic [PW-1:0]            next_pointer_s;
   logic [1:0]               sel_access_s;
   logic [ADDRESS_WIDTH-1:0] sel_address_s;
   logic [BUS_WIDTH-1:0]     sel_write_data_s;
   logic [SW-1:0]            sel_strobe_s;
   logic                     load_s;
   logic                     timeout_s;
   logic                     complete_s;
   logic [1:0]               status_s;
   logic [BUS_WIDTH-1:0]     read_data_s;

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] count_q, count_d;

   assign timeout_s = (state_q == BUSY) && (count_q == CW'(TIMEOUT_CYCLES - 1));

   // Timeout counter register; cleared by reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
`else
   // No timeout in this build; the parameter only appears in a constant-false term.
   assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

   // Completion is suppressed while reset is asserted so an abandoned access never pulses o_ready.
   assign complete_s = i_rst_n && (state_q == BUSY) && (i_ready || timeout_s);

   // A real i_ready always takes priority over a simultaneous timeout.
   always_comb begin
      if (i_ready) begin
         status_s    = i_status;
         read_data_s = i_read_data;
      end else begin
         status_s    = RGGEN_SLAVE_ERROR;
         read_data_s = '0;
      end
   end

   // Pointer value after the current grant completes: (grant + 1) mod REQUESTERS.
   always_comb begin
      next_pointer_s = PW'(rggen_next_index(32'(grant_q), REQUESTERS));
   end

   // Arbiter inputs: while BUSY the completing port is masked out and the search starts after it.
   always_comb begin
      arb_request_s = i_valid;
      arb_pointer_s = pointer_q;
      if (state_q == BUSY) begin
         arb_pointer_s = next_pointer_s;
         for (int i = 0; i < REQUESTERS; i++) begin
            arb_request_s[i] = i_valid[i] && (grant_q != PW'(i));
         end
      end else begin
         arb_pointer_s = pointer_q;
      end
   end

   rggen_round_robin_arbiter #(
      .REQUESTERS (REQUESTERS)
   ) u_round_robin_arbiter (
      .i_request (arb_request_s),
      .i_pointer (arb_pointer_s),
      .o_grant   (arb_grant_s)
   );

   // One-hot grant to index, and AND-OR selection of the winner's request fields.
   always_comb begin
      arb_index_s      = '0;
      sel_access_s     = '0;
      sel_address_s    = '0;
      sel_write_data_s = '0;
      sel_strobe_s     = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         arb_index_s      = arb_index_s | (PW'(i) & {PW{arb_grant_s[i]}});
         sel_access_s     = sel_access_s |
                            (i_access[2*i +: 2] & {2{arb_grant_s[i]}});
         sel_address_s    = sel_address_s |
                            (i_address[ADDRESS_WIDTH*i +: ADDRESS_WIDTH] & {ADDRESS_WIDTH{arb_grant_s[i]}});
         sel_write_data_s = sel_write_data_s |
                            (i_write_data[BUS_WIDTH*i +: BUS_WIDTH] & {BUS_WIDTH{arb_grant_s[i]}});
         sel_strobe_s     = sel_strobe_s |
                            (i_strobe[SW*i +: SW] & {SW{arb_grant_s[i]}});
      end
   end

   // FSM next-state and request-register update.
   always_comb begin
      state_d      = state_q;
      pointer_d    = pointer_q;
      grant_d      = grant_q;
      valid_d      = valid_q;
      access_d     = access_q;
      address_d    = address_q;
      write_data_d = write_data_q;
      strobe_d     = strobe_q;
      load_s       = 1'b0;
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
      count_d      = count_q;
`endif
      case (state_q)
         IDLE: begin
            if (|i_valid) begin
               load_s = 1'b1;
            end else begin
               valid_d = 1'b0;
            end
         end
         BUSY: begin
            if (complete_s) begin
               pointer_d = next_pointer_s;
               if (|arb_request_s) begin
                  load_s = 1'b1;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            end else begin
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
               count_d = count_q + CW'(1);
`endif
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
      if (load_s) begin
         state_d      = BUSY;
         valid_d      = 1'b1;
         grant_d      = arb_index_s;
         access_d     = sel_access_s;
         address_d    = sel_address_s;
         write_data_d = sel_write_data_s;
         strobe_d     = sel_strobe_s;
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
         count_d      = '0;
`endif
      end else begin
         grant_d = grant_d;
      end
   end

   // State, pointer and request registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         pointer_q    <= '0;
         grant_q      <= '0;
         valid_q      <= 1'b0;
         access_q     <= '0;
         address_q    <= '0;
         write_data_q <= '0;
         strobe_q     <= '0;
      end else begin
         state_q      <= state_d;
         pointer_q    <= pointer_d;
         grant_q      <= grant_d;
         valid_q      <= valid_d;
         access_q     <= access_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         strobe_q     <= strobe_d;
      end
   end

   assign o_valid      = valid_q;
   assign o_access     = access_q;
   assign o_address    = address_q;
   assign o_write_data = write_data_q;
   assign o_strobe     = strobe_q;

   // Steer the response to the granted port only on the completion cycle.
   always_comb begin
      o_ready     = '0;
      o_status    = {REQUESTERS{RGGEN_OKAY}};
      o_read_data = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (complete_s && (grant_q == PW'(i))) begin
            o_ready[i]                          = 1'b1;
            o_status[2*i +: 2]                  = status_s;
            o_read_data[BUS_WIDTH*i +: BUS_WIDTH] = read_data_s;
         end else begin
            o_ready[i] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rggen_bus_arbiter
// Directed bench for rggen_bus_arbiter with two requesters. Inputs change on
// the falling edge; outputs are compared 1 ns later. Port 0 issues a write
// to 0x10, port 1 a read of 0x20. The timeout section follows whichever
// build of RGGEN_BUS_ARBITER_TIMEOUT_EN is compiled.
// ---------------------------------------------------------------------------
module tb_rggen_bus_arbiter;

   localparam int N  = 2;
   localparam int AW = 8;
   localparam int BW = 32;
   localparam int SW = BW / 8;
   localparam int TO = 4;

   localparam logic [1:0] OK = 2'b00;
   localparam logic [1:0] EX = 2'b01;
   localparam logic [1:0] SE = 2'b10;

   logic              clk = 1'b0;
   logic              i_rst_n;
   logic [N-1:0]      i_valid;
   logic [2*N-1:0]    i_access;
   logic [AW*N-1:0]   i_address;
   logic [BW*N-1:0]   i_write_data;
   logic [SW*N-1:0]   i_strobe;
   logic [N-1:0]      o_ready;
   logic [2*N-1:0]    o_status;
   logic [BW*N-1:0]   o_read_data;
   logic              o_valid;
   logic [1:0]        o_access;
   logic [AW-1:0]     o_address;
   logic [BW-1:0]     o_write_data;
   logic [SW-1:0]     o_strobe;
   logic              i_ready;
   logic [1:0]        i_status;
   logic [BW-1:0]     i_read_data;

   // Requester request fields (port 0: write, port 1: read).
   logic [1:0]    req_acc  [N] = '{2'b11, 2'b10};
   logic [AW-1:0] req_addr [N] = '{8'h10, 8'h20};
   logic [BW-1:0] req_wd   [N] = '{32'hA5A5_A5A5, 32'h1111_2222};
   logic [SW-1:0] req_stb  [N] = '{4'hF, 4'h0};

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rggen_bus_arbiter #(
      .REQUESTERS     (N),
      .ADDRESS_WIDTH  (AW),
      .BUS_WIDTH      (BW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (i_rst_n),
      .i_valid      (i_valid),
      .i_access     (i_access),
      .i_address    (i_address),
      .i_write_data (i_write_data),
      .i_strobe     (i_strobe),
      .o_ready      (o_ready),
      .o_status     (o_status),
      .o_read_data  (o_read_data),
      .o_valid      (o_valid),
      .o_access     (o_access),
      .o_address    (o_address),
      .o_write_data (o_write_data),
      .o_strobe     (o_strobe),
      .i_ready      (i_ready),
      .i_status     (i_status),
      .i_read_data  (i_read_data)
   );

   typedef struct {
      logic        rst_n;
      logic [1:0]  valid;
      logic        rdy;
      logic [1:0]  st;
      logic [31:0] rd;
      logic        exp_ov;
      logic [1:0]  exp_rdy;
      int          exp_gnt;   // >=0 granted port fields, -1 all zero, -2 not checked
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic rst_n, input logic [1:0] valid, input logic rdy,
                               input logic [1:0] st, input logic [31:0] rd, input logic exp_ov,
                               input logic [1:0] exp_rdy, input int exp_gnt);
      vec_t v;
      v.rst_n = rst_n; v.valid = valid; v.rdy = rdy; v.st = st; v.rd = rd;
      v.exp_ov = exp_ov; v.exp_rdy = exp_rdy; v.exp_gnt = exp_gnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst_n, input logic [1:0] valid, input logic rdy,
                        input logic [1:0] st, input logic [31:0] rd);
      @(negedge clk);
      i_rst_n     = rst_n;
      i_valid     = valid;
      i_ready     = rdy;
      i_status    = st;
      i_read_data = rd;
      #1;
   endtask

   task automatic check_cycle(input string tag, input logic ov, input logic [1:0] rdy,
                              input logic [1:0] st0, input logic [1:0] st1,
                              input logic [31:0] rd0, input logic [31:0] rd1, input int gnt);
      chk({tag, " o_valid"}, 64'(o_valid), 64'(ov));
      chk({tag, " o_ready"}, 64'(o_ready), 64'(rdy));
      chk({tag, " o_status0"}, 64'(o_status[1:0]), 64'(st0));
      chk({tag, " o_status1"}, 64'(o_status[3:2]), 64'(st1));
      chk({tag, " o_read_data0"}, 64'(o_read_data[31:0]), 64'(rd0));
      chk({tag, " o_read_data1"}, 64'(o_read_data[63:32]), 64'(rd1));
      if (gnt >= 0) begin
         chk({tag, " o_fields"}, {o_access, o_address, o_write_data, o_strobe},
             64'({req_acc[gnt], req_addr[gnt], req_wd[gnt], req_stb[gnt]}));
      end else if (gnt == -1) begin
         chk({tag, " o_fields_zero"}, {o_access, o_address, o_write_data, o_strobe}, 64'd0);
      end
   endtask

   initial begin
      logic [1:0]  e_st0, e_st1;
      logic [31:0] e_rd0, e_rd1;
      logic        saw_ready, saw_drop;

      vecs[0]  = mk(1'b0, 2'b00, 1'b0, OK, 32'h0,         1'b0, 2'b00, -1);
      // single requester write, ready on third BUSY cycle
      vecs[1]  = mk(1'b1, 2'b01, 1'b0, OK, 32'h0,         1'b0, 2'b00, -1);
      vecs[2]  = mk(1'b1, 2'b01, 1'b0, OK, 32'hFFFF_FFFF, 1'b1, 2'b00,  0);
      vecs[3]  = mk(1'b1, 2'b01, 1'b0, OK, 32'hFFFF_FFFF, 1'b1, 2'b00,  0);
      vecs[4]  = mk(1'b1, 2'b01, 1'b1, OK, 32'hDEAD_BEEF, 1'b1, 2'b01,  0);
      vecs[5]  = mk(1'b1, 2'b00, 1'b0, OK, 32'h0,         1'b0, 2'b00, -2);
      // read passthrough on port 1, then a slave error on port 0
      vecs[6]  = mk(1'b1, 2'b10, 1'b0, OK, 32'h0,         1'b0, 2'b00, -2);
      vecs[7]  = mk(1'b1, 2'b10, 1'b1, OK, 32'h1234_5678, 1'b1, 2'b10,  1);
      vecs[8]  = mk(1'b1, 2'b00, 1'b0, OK, 32'h0,         1'b0, 2'b00, -2);
      vecs[9]  = mk(1'b1, 2'b01, 1'b0, OK, 32'h0,         1'b0, 2'b00, -2);
      vecs[10] = mk(1'b1, 2'b01, 1'b1, SE, 32'hCAFE_0001, 1'b1, 2'b01,  0);
      // contention from reset: 0,1,0,1 back to back
      vecs[11] = mk(1'b0, 2'b11, 1'b0, OK, 32'h0,         1'b0, 2'b00, -2);
      vecs[12] = mk(1'b1, 2'b11, 1'b0, OK, 32'h0,         1'b0, 2'b00, -1);
      vecs[13] = mk(1'b1, 2'b11, 1'b1, OK, 32'h0000_00A0, 1'b1, 2'b01,  0);
      vecs[14] = mk(1'b1, 2'b11, 1'b1, OK, 32'h0000_00A1, 1'b1, 2'b10,  1);
      vecs[15] = mk(1'b1, 2'b11, 1'b1, OK, 32'h0000_00A2, 1'b1, 2'b01,  0);
      vecs[16] = mk(1'b1, 2'b10, 1'b1, OK, 32'h0000_00A3, 1'b1, 2'b10,  1);
      vecs[17] = mk(1'b1, 2'b00, 1'b0, OK, 32'h0,         1'b0, 2'b00, -2);
      // move pointer to 1, then reset in the second BUSY cycle
      vecs[18] = mk(1'b1, 2'b01, 1'b0, OK, 32'h0,         1'b0, 2'b00, -2);
      vecs[19] = mk(1'b1, 2'b01, 1'b1, OK, 32'h0,         1'b1, 2'b01,  0);
      vecs[20] = mk(1'b1, 2'b00, 1'b0, OK, 32'h0,         1'b0, 2'b00, -2);
      vecs[21] = mk(1'b1, 2'b01, 1'b0, OK, 32'h0,         1'b0, 2'b00, -2);
      vecs[22] = mk(1'b1, 2'b01, 1'b0, OK, 32'h0,         1'b1, 2'b00,  0);
      vecs[23] = mk(1'b0, 2'b01, 1'b1, OK, 32'h5555_AAAA, 1'b1, 2'b00,  0);
      vecs[24] = mk(1'b1, 2'b11, 1'b0, OK, 32'h0,         1'b0, 2'b00, -1);
      vecs[25] = mk(1'b1, 2'b11, 1'b1, OK, 32'h0,         1'b1, 2'b01,  0);
      vecs[26] = mk(1'b1, 2'b10, 1'b1, OK, 32'h0,         1'b1, 2'b10,  1);
      vecs[27] = mk(1'b1, 2'b00, 1'b0, OK, 32'h0,         1'b0, 2'b00, -2);

      i_access     = {req_acc[1], req_acc[0]};
      i_address    = {req_addr[1], req_addr[0]};
      i_write_data = {req_wd[1], req_wd[0]};
      i_strobe     = {req_stb[1], req_stb[0]};
      i_rst_n      = 1'b0;
      i_valid      = 2'b00;
      i_ready      = 1'b0;
      i_status     = OK;
      i_read_data  = 32'h0;
      repeat (3) @(negedge clk);

      for (int r = 0; r < NV; r++) begin
         drive(vecs[r].rst_n, vecs[r].valid, vecs[r].rdy, vecs[r].st, vecs[r].rd);
         e_st0 = vecs[r].exp_rdy[0] ? vecs[r].st : OK;
         e_st1 = vecs[r].exp_rdy[1] ? vecs[r].st : OK;
         e_rd0 = vecs[r].exp_rdy[0] ? vecs[r].rd : 32'h0;
         e_rd1 = vecs[r].exp_rdy[1] ? vecs[r].rd : 32'h0;
         check_cycle($sformatf("row%0d", r), vecs[r].exp_ov, vecs[r].exp_rdy,
                     e_st0, e_st1, e_rd0, e_rd1, vecs[r].exp_gnt);
      end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
      // port 0 alone, target silent: forced error on the 4th BUSY cycle
      drive(1'b1, 2'b01, 1'b0, OK, 32'hFFFF_FFFF);
      check_cycle("to_idle0", 1'b0, 2'b00, OK, OK, 32'h0, 32'h0, -2);
      for (int k = 1; k <= TO; k++) begin
         drive(1'b1, 2'b01, 1'b0, OK, 32'hFFFF_FFFF);
         check_cycle($sformatf("to_a%0d", k), 1'b1, (k == TO) ? 2'b01 : 2'b00,
                     (k == TO) ? SE : OK, OK, 32'h0, 32'h0, 0);
      end
      // both ports: port 1 times out, then port 0 with a fresh count gets i_ready on the 4th cycle
      drive(1'b1, 2'b11, 1'b0, OK, 32'hFFFF_FFFF);
      check_cycle("to_idle1", 1'b0, 2'b00, OK, OK, 32'h0, 32'h0, -2);
      for (int k = 1; k <= TO; k++) begin
         drive(1'b1, 2'b11, 1'b0, OK, 32'hFFFF_FFFF);
         check_cycle($sformatf("to_b%0d", k), 1'b1, (k == TO) ? 2'b10 : 2'b00,
                     OK, (k == TO) ? SE : OK, 32'h0, 32'h0, 1);
      end
      for (int k = 1; k <= TO; k++) begin
         drive(1'b1, 2'b01, (k == TO), EX, 32'h600D_0000);
         check_cycle($sformatf("to_c%0d", k), 1'b1, (k == TO) ? 2'b01 : 2'b00,
                     (k == TO) ? EX : OK, OK, (k == TO) ? 32'h600D_0000 : 32'h0, 32'h0, 0);
      end
      drive(1'b1, 2'b00, 1'b0, OK, 32'h0);
      check_cycle("to_end", 1'b0, 2'b00, OK, OK, 32'h0, 32'h0, -2);
`else
      // no timeout build: BUSY holds for 100 cycles without a completion
      drive(1'b1, 2'b01, 1'b0, OK, 32'hFFFF_FFFF);
      check_cycle("nto_idle", 1'b0, 2'b00, OK, OK, 32'h0, 32'h0, -2);
      saw_ready = 1'b0;
      saw_drop  = 1'b0;
      for (int k = 0; k < 100; k++) begin
         drive(1'b1, 2'b01, 1'b0, OK, 32'hFFFF_FFFF);
         saw_ready = saw_ready | (|o_ready);
         saw_drop  = saw_drop | !o_valid;
      end
      chk("nto_no_ready", 64'(saw_ready), 64'd0);
      chk("nto_valid_held", 64'(saw_drop), 64'd0);
      drive(1'b0, 2'b00, 1'b0, OK, 32'h0);
      check_cycle("nto_rst", 1'b1, 2'b00, OK, OK, 32'h0, 32'h0, 0);
      drive(1'b1, 2'b00, 1'b0, OK, 32'h0);
      check_cycle("nto_after", 1'b0, 2'b00, OK, OK, 32'h0, 32'h0, -1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
